deserializer: RTL and testbench

Serial-to-parallel receiver for the single-lane MSB-first bit stream produced by the team's serializer. Samples one bit per clock while the serial valid strobe is high and assembles the bits into a left-aligned parallel word. Emits the word with a one-cycle valid pulse and a bit-count field that uses the serializer's length encoding. Sits at the receive end of the link and feeds parallel consumers that accept one word per pulse without backpressure.

---
 rtl/deserializer.sv | 115 +++++++++++
 tb/tb_deserializer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// deserializer: single-lane MSB-first serial-to-parallel receiver.
// Bits are sampled while ser_data_val_i is high and packed into a
// left-aligned DATA_W-bit word, which is emitted with a one-cycle
// deser_data_val_o pulse and a bit-count field (0 means a full word).
//
// Optional feature, macro DESERIALIZER_PARTIAL_EN:
//   defined   - a val gap after k < DATA_W bits flushes a left-aligned,
//               zero-filled partial word with deser_data_mod_o = k.
//   undefined - a val gap silently drops the held bits; mod is always 0
//               and the left-align shifter is not built.
module deserializer #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o,
  output logic              busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // count holds 0..DATA_W-1 between edges; one extra bit keeps DATA_W representable
  localparam logic [MOD_W:0] LAST_CNT = (MOD_W+1)'(DATA_W - 1);

  state_t            state;
  logic [MOD_W:0]    count;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic [DATA_W-1:0] data_q;
  logic [MOD_W-1:0]  mod_q;
  logic              val_q;

  // Next shift-register value with the current serial bit appended at the LSB
  assign shreg_next = {shreg[DATA_W-2:0], ser_data_i};

`ifdef DESERIALIZER_PARTIAL_EN
  localparam logic [MOD_W:0] FULL_CNT = (MOD_W+1)'(DATA_W);

  logic [MOD_W:0]    shamt;
  logic [DATA_W-1:0] partial_word;

  // Left-align the k held bits; stale high bits are shifted out, zeros fill in
  assign shamt        = FULL_CNT - count;
  assign partial_word = shreg << shamt;
`else
  // The shreg MSB is only consumed by the partial-word aligner
  logic unused_shreg_msb;
  assign unused_shreg_msb = shreg[DATA_W-1];
`endif

  // Receive FSM: bit accumulation, word completion and gap handling
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state  <= IDLE;
      count  <= '0;
      shreg  <= '0;
      data_q <= '0;
      mod_q  <= '0;
      val_q  <= 1'b0;
    end else begin
      val_q <= 1'b0;
      if (ser_data_val_i) begin
        if (count == LAST_CNT) begin
          // Final bit of the word: publish it and start fresh next cycle,
          // so a continuous burst loses no bit across word boundaries
          data_q <= shreg_next;
          mod_q  <= '0;
          val_q  <= 1'b1;
          count  <= '0;
          shreg  <= '0;
          state  <= IDLE;
        end else begin
          shreg <= shreg_next;
          count <= count + (MOD_W+1)'(1);
          state <= RECV;
        end
      end else begin
        case (state)
          RECV: begin
`ifdef DESERIALIZER_PARTIAL_EN
            data_q <= partial_word;
            mod_q  <= count[MOD_W-1:0];
            val_q  <= 1'b1;
`endif
            count <= '0;
            shreg <= '0;
            state <= IDLE;
          end
          IDLE: begin
            state <= IDLE;
          end
          default: begin
            count <= '0;
            shreg <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign deser_data_o     = data_q;
  assign deser_data_mod_o = mod_q;
  assign deser_data_val_o = val_q;
  assign busy_o           = (count != '0);

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer (DATA_W = 16).
// Expected words are queued when a burst is driven and compared by a
// monitor when deser_data_val_o pulses. Build with DESERIALIZER_PARTIAL_EN
// defined to exercise partial-word flushing.
module tb_deserializer;

  localparam int DW = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          ser_data;
  logic          ser_val;
  logic [DW-1:0] deser_data;
  logic [MW-1:0] deser_mod;
  logic          deser_val;
  logic          busy;

`ifdef DESERIALIZER_PARTIAL_EN
  localparam bit PARTIAL = 1'b1;
`else
  localparam bit PARTIAL = 1'b0;
`endif

  deserializer #(.DATA_W(DW), .MOD_W(MW)) dut (
    .clk_i            (clk),
    .arst_n_i         (arst_n),
    .ser_data_i       (ser_data),
    .ser_data_val_i   (ser_val),
    .deser_data_o     (deser_data),
    .deser_data_mod_o (deser_mod),
    .deser_data_val_o (deser_val),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [MW-1:0] mod;
  } exp_t;

  typedef struct {
    logic [DW-1:0] word;
    int            nbits;
    bit            exp_pulse;
    logic [DW-1:0] exp_data;
    logic [MW-1:0] exp_mod;
  } vec_t;

  exp_t sb[$];
  int   pulse_cyc[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pulse_cnt = 0;
  int   exp_pulses = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_word(input logic [DW-1:0] d, input logic [MW-1:0] m);
    exp_t e;
    e.data = d;
    e.mod  = m;
    sb.push_back(e);
    exp_pulses++;
  endtask

  // Monitor: every pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (deser_val === 1'b1) begin
      pulse_cnt++;
      pulse_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse actual data=%h mod=%0d required no pulse", deser_data, deser_mod);
      end else begin
        e = sb.pop_front();
        check("word_data", 32'(deser_data), 32'(e.data));
        check("word_mod", 32'(deser_mod), 32'(e.mod));
      end
    end
  end

  task automatic send_bit(input logic b);
    ser_data = b;
    ser_val  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ser_val  = 1'b0;
    ser_data = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(w[DW-1-i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  vec_t vecs[7];
  logic [DW-1:0] rnd;

  initial begin
    vecs[0] = '{16'hA5C3, 16, 1'b1, 16'hA5C3, 4'd0};
    vecs[1] = '{16'h0000, 16, 1'b1, 16'h0000, 4'd0};
    vecs[2] = '{16'hFFFF, 16, 1'b1, 16'hFFFF, 4'd0};
    vecs[3] = '{16'h8001, 16, 1'b1, 16'h8001, 4'd0};
    vecs[4] = '{16'hB000,  5, PARTIAL, 16'hB000, 4'd5};
    vecs[5] = '{16'h8000,  1, PARTIAL, 16'h8000, 4'd1};
    vecs[6] = '{16'hFFFF, 15, PARTIAL, 16'hFFFE, 4'd15};

    arst_n   = 1'b0;
    ser_val  = 1'b0;
    ser_data = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(deser_data), 32'h0);
    check("rst_mod", 32'(deser_mod), 32'h0);
    check("rst_val", 32'(deser_val), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    arst_n = 1'b1;
    idle(2);

    // Single full word: pulse timing and busy behaviour
    expect_word(16'hA5C3, 4'd0);
    send_word(16'hA5C3, 15);
    check("t1_busy_before", 32'(busy), 32'h1);
    check("t1_val_before", 32'(deser_val), 32'h0);
    send_bit(1'b1);
    check("t1_val_pulse", 32'(deser_val), 32'h1);
    check("t1_busy_after", 32'(busy), 32'h0);
    check("t1_data", 32'(deser_data), 32'hA5C3);
    idle(1);
    check("t1_val_drop", 32'(deser_val), 32'h0);
    check("t1_data_hold", 32'(deser_data), 32'hA5C3);

    // Reset mid-word: outputs clear at once, no pulse, next word clean
    send_word(16'h7F3C, 9);
    check("mid_busy", 32'(busy), 32'h1);
    arst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(deser_data), 32'h0);
    check("mid_rst_val", 32'(deser_val), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    ser_val = 1'b0;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    idle(2);
    expect_word(16'h8001, 4'd0);
    send_word(16'h8001, 16);
    idle(2);

    // Back-to-back words on one continuous burst
    pulse_cyc.delete();
    expect_word(16'h1234, 4'd0);
    expect_word(16'hFFFF, 4'd0);
    send_word(16'h1234, 16);
    send_word(16'hFFFF, 16);
    idle(2);
    check("b2b_pulses", 32'(pulse_cyc.size()), 32'd2);
    if (pulse_cyc.size() == 2)
      check("b2b_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd16);

    // Short burst followed by a full word
    if (PARTIAL) expect_word(16'hB000, 4'd5);
    send_word(16'hB000, 5);
    idle(1);
    check("stray_val", 32'(deser_val), 32'(PARTIAL));
    check("stray_busy", 32'(busy), 32'h0);
    idle(1);
    expect_word(16'h00FF, 4'd0);
    send_word(16'h00FF, 16);
    check("stray_next_data", 32'(deser_data), 32'h00FF);
    idle(2);

    // Table of single bursts; pulse must appear right after the last bit
    // (full) or right after the first idle edge (partial)
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].exp_pulse) expect_word(vecs[v].exp_data, vecs[v].exp_mod);
      send_word(vecs[v].word, vecs[v].nbits);
      if (vecs[v].nbits < DW) idle(1);
      check($sformatf("vec%0d_val", v), 32'(deser_val), 32'(vecs[v].exp_pulse));
      idle(2);
    end

    // Loopback against a serializer model: random words, one idle between
    for (int n = 0; n < 20; n++) begin
      rnd = DW'($urandom);
      expect_word(rnd, 4'd0);
      send_word(rnd, DW);
      idle(1);
    end

    idle(3);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("pulse_count", 32'(pulse_cnt), 32'(exp_pulses));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
